jchain_loader: RTL and testbench

- Serial word loader directly upstream of the CPU core's data and instruction memories.
- While Jen is high it accepts one 32-bit word per clock on Jin and writes it into memory. Loading is top-down: first data memory addresses DEPTH-1..0, then instruction memory addresses DEPTH-1..0.
- Each displaced memory word is shifted out on Jout for readback.
- Holds the core in reset until a complete image has been loaded.

---
 rtl/jchain_loader.sv | 129 ++++++++++++
 tb/tb_jchain_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/jchain_loader.sv
// Serial image loader: fills data then instruction memory top-down from Jin,
// shifts displaced words out on Jout, and holds the core until complete.
// Optional running checksum output enabled by JCHAIN_LOADER_CHECKSUM_EN.
module jchain_loader #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Jen,
  input  logic [31:0]   Jin,
  output logic [31:0]   Jout,
  output logic          dmem_we,
  output logic          imem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   dmem_rdata,
  input  logic [31:0]   imem_rdata,
  output logic          core_hold,
  output logic          load_done,
  output logic          load_err
`ifdef JCHAIN_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]   chksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD_D, LOAD_I, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic          err_nx;
  logic          wr_d, wr_i;
  logic          vld_p1;
  logic          sel_i_p1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = load_err;
    wr_d     = 1'b0;
    wr_i     = 1'b0;
    case (state)
      IDLE, DONE: begin
        // The first word is written in the same cycle Jen is seen high.
        if (Jen) begin
          wr_d     = 1'b1;
          state_nx = LOAD_D;
          cnt_nx   = AW'(1);
        end
      end
      LOAD_D: begin
        if (Jen) begin
          wr_d   = 1'b1;
          cnt_nx = cnt + AW'(1);
          if (cnt == LAST) state_nx = LOAD_I;
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
          err_nx   = 1'b1;
        end
      end
      LOAD_I: begin
        if (Jen) begin
          wr_i   = 1'b1;
          cnt_nx = cnt + AW'(1);
          if (cnt == LAST) begin
            state_nx = DONE;
            err_nx   = 1'b0;
          end
        end else begin
          state_nx = IDLE;
          cnt_nx   = '0;
          err_nx   = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Strobes are masked while reset is asserted so no write leaks out mid-reset.
  assign dmem_we   = wr_d & rst;
  assign imem_we   = wr_i & rst;
  assign mem_addr  = LAST - cnt;
  assign mem_wdata = Jin;
  assign load_done = (state == DONE);
  assign core_hold = (state != DONE);

  // p0: accept/write stage; p1: memory read data returns and is captured on Jout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      load_err <= 1'b0;
      vld_p1   <= 1'b0;
      sel_i_p1 <= 1'b0;
      Jout     <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      load_err <= err_nx;
      vld_p1   <= wr_d | wr_i;
      sel_i_p1 <= wr_i;
      if (vld_p1) Jout <= sel_i_p1 ? imem_rdata : dmem_rdata;
    end
  end

`ifdef JCHAIN_LOADER_CHECKSUM_EN
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chksum <= '0;
    end else if (wr_d && (state == IDLE || state == DONE)) begin
      chksum <= Jin;
    end else if (wr_d || wr_i) begin
      chksum <= wrap_add(chksum, Jin);
    end
  end
`endif

endmodule

// File: tb/tb_jchain_loader.sv
// Directed self-checking bench for jchain_loader with read-before-write
// memory models; checksum checks compile in with JCHAIN_LOADER_CHECKSUM_EN.
module tb_jchain_loader;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Jen = 1'b0;
  logic [31:0]   Jin = '0;
  logic [31:0]   Jout;
  logic          dmem_we, imem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   dmem_rdata, imem_rdata;
  logic          core_hold, load_done, load_err;
`ifdef JCHAIN_LOADER_CHECKSUM_EN
  logic [31:0]   chksum;
`endif

  logic [31:0]   dmem [DEPTH];
  logic [31:0]   imem [DEPTH];
  logic          preload = 1'b0;
  logic [31:0]   preload_val = '0;

  int vectors = 0;
  int errors  = 0;

  jchain_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .Jen(Jen), .Jin(Jin), .Jout(Jout),
    .dmem_we(dmem_we), .imem_we(imem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dmem_rdata(dmem_rdata), .imem_rdata(imem_rdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err)
`ifdef JCHAIN_LOADER_CHECKSUM_EN
    , .chksum(chksum)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous read-before-write memories
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) begin
        dmem[i] <= preload_val;
        imem[i] <= preload_val;
      end
    end else begin
      if (dmem_we) dmem[mem_addr] <= mem_wdata;
      if (imem_we) imem[mem_addr] <= mem_wdata;
    end
    dmem_rdata <= dmem[mem_addr];
    imem_rdata <= imem[mem_addr];
  end

  function automatic logic [31:0] pat(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'd3;
  endfunction

  task automatic push(input logic [31:0] w);
    Jen = 1'b1;
    Jin = w;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    Jen = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_preload(input logic [31:0] v);
    Jen = 1'b0;
    preload_val = v;
    preload = 1'b1;
    @(posedge clk);
    #1;
    preload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    do_preload(32'h0);
    Jen = 1'b1;
    Jin = 32'h55;
    #2;
    vectors++; if (core_hold !== 1'b1) begin errors++; $display("FAIL reset_core_hold got=%0b exp=1", core_hold); end
    vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done got=%0b exp=0", load_done); end
    vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got=%0b exp=0", load_err); end
    vectors++; if (Jout !== 32'h0) begin errors++; $display("FAIL reset_jout got=%h exp=0", Jout); end
    vectors++; if (dmem_we !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b%0b exp=00", dmem_we, imem_we); end
`ifdef JCHAIN_LOADER_CHECKSUM_EN
    vectors++; if (chksum !== 32'h0) begin errors++; $display("FAIL reset_chksum got=%h exp=0", chksum); end
`endif
    Jen = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
  endtask

  task automatic test_full_load();
    Jen = 1'b1;
    Jin = 32'h1000;
    #1;
    vectors++; if (dmem_we !== 1'b1 || imem_we !== 1'b0 || mem_addr !== 9'd511) begin errors++; $display("FAIL first_word_addr got we=%0b%0b addr=%0d exp we=10 addr=511", dmem_we, imem_we, mem_addr); end
    for (int k = 0; k < 2 * DEPTH; k++) begin
      if (k == DEPTH) begin
        Jen = 1'b1;
        Jin = 32'h1000 + 32'(k);
        #1;
        vectors++; if (imem_we !== 1'b1 || dmem_we !== 1'b0 || mem_addr !== 9'd511) begin errors++; $display("FAIL instr_start got we=%0b%0b addr=%0d exp we=01 addr=511", dmem_we, imem_we, mem_addr); end
      end
      if (k == 2 * DEPTH - 1) begin
        vectors++; if (load_done !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL pre_last_word got done=%0b hold=%0b exp done=0 hold=1", load_done, core_hold); end
      end
      push(32'h1000 + 32'(k));
      if (k == 0) begin
        vectors++; if (mem_addr !== 9'd510 || dmem_we !== 1'b1) begin errors++; $display("FAIL second_addr got addr=%0d we=%0b exp addr=510 we=1", mem_addr, dmem_we); end
      end
    end
    vectors++; if (load_done !== 1'b1 || core_hold !== 1'b0) begin errors++; $display("FAIL full_done got done=%0b hold=%0b exp done=1 hold=0", load_done, core_hold); end
    vectors++; if (load_err !== 1'b0) begin errors++; $display("FAIL full_err got=%0b exp=0", load_err); end
    vectors++; if (dmem[511] !== 32'h1000) begin errors++; $display("FAIL dmem511 got=%h exp=00001000", dmem[511]); end
    vectors++; if (dmem[0] !== 32'h11FF) begin errors++; $display("FAIL dmem0 got=%h exp=000011ff", dmem[0]); end
    vectors++; if (imem[511] !== 32'h1200) begin errors++; $display("FAIL imem511 got=%h exp=00001200", imem[511]); end
    vectors++; if (imem[0] !== 32'h13FF) begin errors++; $display("FAIL imem0 got=%h exp=000013ff", imem[0]); end
    idle_cycle();
    vectors++; if (load_done !== 1'b1 || dmem_we !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL done_hold got done=%0b we=%0b%0b exp done=1 we=00", load_done, dmem_we, imem_we); end
  endtask

  task automatic test_abort();
    Jen = 1'b1;
    Jin = 32'hABCD_0000;
    #1;
    vectors++; if (dmem_we !== 1'b1 || mem_addr !== 9'd511) begin errors++; $display("FAIL restart_addr got we=%0b addr=%0d exp we=1 addr=511", dmem_we, mem_addr); end
    push(32'hABCD_0000);
    vectors++; if (load_done !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL restart_flags got done=%0b hold=%0b exp done=0 hold=1", load_done, core_hold); end
    vectors++; if (dmem[511] !== 32'hABCD_0000) begin errors++; $display("FAIL restart_write got=%h exp=abcd0000", dmem[511]); end
    for (int k = 1; k < 300; k++) push(32'hABCD_0000 + 32'(k));
    idle_cycle();
    vectors++; if (load_err !== 1'b1 || load_done !== 1'b0 || core_hold !== 1'b1) begin errors++; $display("FAIL abort_flags got err=%0b done=%0b hold=%0b exp 1 0 1", load_err, load_done, core_hold); end
    vectors++; if (mem_addr !== 9'd511) begin errors++; $display("FAIL abort_cnt got addr=%0d exp=511", mem_addr); end
    vectors++; if (dmem[212] !== 32'hABCD_012B || imem[0] !== 32'h13FF) begin errors++; $display("FAIL abort_mem got d212=%h i0=%h exp abcd012b 000013ff", dmem[212], imem[0]); end
    idle_cycle();
    vectors++; if (load_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0b exp=1", load_err); end
    push(32'h2000);
    vectors++; if (load_err !== 1'b1 || dmem[511] !== 32'h2000) begin errors++; $display("FAIL reload_start got err=%0b d511=%h exp err=1 d511=00002000", load_err, dmem[511]); end
    for (int k = 1; k < 2 * DEPTH; k++) push(32'h2000 + 32'(k));
    vectors++; if (load_err !== 1'b0 || load_done !== 1'b1) begin errors++; $display("FAIL reload_done got err=%0b done=%0b exp err=0 done=1", load_err, load_done); end
    idle_cycle();
  endtask

  task automatic test_readback();
    do_preload(32'hDEAD_BEEF);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      push(pat(k));
      if (k >= 1) begin
        vectors++; if (Jout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rb1_word%0d got=%h exp=deadbeef", k - 1, Jout); end
      end
    end
    idle_cycle();
    vectors++; if (Jout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rb1_last got=%h exp=deadbeef", Jout); end
    for (int k = 0; k < 2 * DEPTH; k++) begin
      push(pat(k));
      if (k >= 1) begin
        vectors++; if (Jout !== pat(k - 1)) begin errors++; $display("FAIL rb2_word%0d got=%h exp=%h", k - 1, Jout, pat(k - 1)); end
      end
    end
    idle_cycle();
    vectors++; if (Jout !== pat(2 * DEPTH - 1)) begin errors++; $display("FAIL rb2_last got=%h exp=%h", Jout, pat(2 * DEPTH - 1)); end
    idle_cycle();
    vectors++; if (Jout !== pat(2 * DEPTH - 1)) begin errors++; $display("FAIL rb_hold got=%h exp=%h", Jout, pat(2 * DEPTH - 1)); end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 699; k++) push(32'h7000 + 32'(k));
    Jen = 1'b1;
    Jin = 32'h7000 + 32'd699;
    #1;
    vectors++; if (imem_we !== 1'b1) begin errors++; $display("FAIL pre_reset_imem_we got=%0b exp=1", imem_we); end
    #1;
    rst = 1'b0;
    #1;
    vectors++; if (core_hold !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL async_flags got hold=%0b done=%0b err=%0b exp 1 0 0", core_hold, load_done, load_err); end
    vectors++; if (Jout !== 32'h0) begin errors++; $display("FAIL async_jout got=%h exp=0", Jout); end
    vectors++; if (dmem_we !== 1'b0 || imem_we !== 1'b0) begin errors++; $display("FAIL async_we got=%0b%0b exp=00", dmem_we, imem_we); end
    #2;
    rst = 1'b1;
    Jin = 32'h7777;
    #1;
    vectors++; if (dmem_we !== 1'b1 || mem_addr !== 9'd511) begin errors++; $display("FAIL post_reset_addr got we=%0b addr=%0d exp we=1 addr=511", dmem_we, mem_addr); end
    @(posedge clk);
    #1;
    vectors++; if (dmem[511] !== 32'h7777 || load_err !== 1'b0) begin errors++; $display("FAIL post_reset_write got d511=%h err=%0b exp 00007777 0", dmem[511], load_err); end
    for (int k = 1; k < 2 * DEPTH; k++) push(32'h7777 + 32'(k));
    vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL post_reset_done got=%0b exp=1", load_done); end
    idle_cycle();
  endtask

`ifdef JCHAIN_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    for (int k = 0; k < 2 * DEPTH; k++) push(32'(k) + 32'd1);
    vectors++; if (chksum !== 32'h0008_0200 || load_done !== 1'b1) begin errors++; $display("FAIL chksum got=%h done=%0b exp=00080200 done=1", chksum, load_done); end
    idle_cycle();
    vectors++; if (chksum !== 32'h0008_0200) begin errors++; $display("FAIL chksum_frozen got=%h exp=00080200", chksum); end
    push(32'h0000_0042);
    vectors++; if (chksum !== 32'h0000_0042) begin errors++; $display("FAIL chksum_restart got=%h exp=00000042", chksum); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_load();
    test_abort();
    test_readback();
    test_async_reset();
`ifdef JCHAIN_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
